tlul_peri_bridge: RTL and testbench

Registered TL-UL pipeline stage between the main crossbar's peripheral port (host side) and the peripheral crossbar's main port (device side). It replaces the current direct wire connection.
- Breaks the combinational a_ready/d_ready paths between the two crossbars.
- Buffers A-channel requests and D-channel responses in FIFOs.
- Caps the number of outstanding transactions on the peripheral bus.
- Sits on the main/fixed clock domain; no clock crossing.

---
 rtl/tlul_pkg.sv | 51 +++++
 rtl/tlul_bridge_fifo.sv | 72 +++++++
 rtl/tlul_peri_bridge.sv | 186 ++++++++++++++++++
 tb/tb_tlul_peri_bridge.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tlul_pkg.sv
// TL-UL bus types shared by the crossbars and the peripheral bridge.
// Field widths match the main/peripheral crossbar configuration.
package tlul_pkg;

    localparam int unsigned TL_AW  = 32;
    localparam int unsigned TL_DW  = 32;
    localparam int unsigned TL_DBW = TL_DW / 8;
    localparam int unsigned TL_SZW = 2;
    localparam int unsigned TL_AIW = 8;
    localparam int unsigned TL_DIW = 1;
    localparam int unsigned TL_AUW = 16;
    localparam int unsigned TL_DUW = 16;

    typedef enum logic [2:0] {
        PutFullData    = 3'h0,
        PutPartialData = 3'h1,
        Get            = 3'h4
    } tl_a_op_e;

    typedef enum logic [2:0] {
        AccessAck     = 3'h0,
        AccessAckData = 3'h1
    } tl_d_op_e;

    typedef struct packed {
        logic              a_valid;
        tl_a_op_e          a_opcode;
        logic [2:0]        a_param;
        logic [TL_SZW-1:0] a_size;
        logic [TL_AIW-1:0] a_source;
        logic [TL_AW-1:0]  a_address;
        logic [TL_DBW-1:0] a_mask;
        logic [TL_DW-1:0]  a_data;
        logic [TL_AUW-1:0] a_user;
        logic              d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic              d_valid;
        tl_d_op_e          d_opcode;
        logic [2:0]        d_param;
        logic [TL_SZW-1:0] d_size;
        logic [TL_AIW-1:0] d_source;
        logic [TL_DIW-1:0] d_sink;
        logic [TL_DW-1:0]  d_data;
        logic [TL_DUW-1:0] d_user;
        logic              d_error;
        logic              a_ready;
    } tl_d2h_t;

endpackage

// File: rtl/tlul_bridge_fifo.sv
// Generic synchronous FIFO: registered full/empty, no fall-through and no full-bypass.
// Storage is cleared on reset so idle outputs are all-zero.
module tlul_bridge_fifo #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 2,
    localparam int unsigned CntW = $clog2(Depth + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             wvalid,
    output logic             wready,
    input  logic [Width-1:0] wdata,
    output logic             rvalid,
    input  logic             rready,
    output logic [Width-1:0] rdata,
    output logic [CntW-1:0]  depth
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wptr_q;
    logic [PtrW-1:0]  rptr_q;
    logic [CntW-1:0]  cnt_q;
    logic             push;
    logic             pop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    assign wready = (cnt_q != CntW'(Depth));
    assign rvalid = (cnt_q != '0);
    assign push   = wvalid && wready;
    assign pop    = rvalid && rready;
    assign rdata  = mem_q[rptr_q];
    assign depth  = cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            for (int i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (push) begin
                mem_q[wptr_q] <= wdata;
                wptr_q        <= ptr_inc(wptr_q);
            end
            if (pop) begin
                rptr_q <= ptr_inc(rptr_q);
            end
            if (push && !pop) begin
                cnt_q <= cnt_q + CntW'(1);
            end else if (pop && !push) begin
                cnt_q <= cnt_q - CntW'(1);
            end
        end
    end

    if (Depth < 1) begin : gen_depth_check
        $error("tlul_bridge_fifo: Depth must be >= 1");
    end

    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        push |-> (cnt_q < CntW'(Depth)));
    a_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        pop |-> (cnt_q != '0));

endmodule

// File: rtl/tlul_peri_bridge.sv
// Registered TL-UL stage between the main crossbar peripheral port and the peripheral
// crossbar; buffers both channels and caps outstanding transactions.
module tlul_peri_bridge
    import tlul_pkg::*;
#(
    parameter int unsigned ReqDepth       = 2,
    parameter int unsigned RspDepth       = 2,
    parameter int unsigned MaxOutstanding = 2,
    localparam int unsigned OutW          = $clog2(MaxOutstanding + 1)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  tl_h2d_t         tl_h_i,
    output tl_d2h_t         tl_h_o,
    output tl_h2d_t         tl_d_o,
    input  tl_d2h_t         tl_d_i,
    output logic [OutW-1:0] outstanding_o,
    output logic            idle_o
);

    localparam int unsigned ReqCntW = $clog2(ReqDepth + 1);
    localparam int unsigned RspCntW = $clog2(RspDepth + 1);

    typedef struct packed {
        tl_a_op_e          opcode;
        logic [2:0]        param;
        logic [TL_SZW-1:0] size;
        logic [TL_AIW-1:0] source;
        logic [TL_AW-1:0]  address;
        logic [TL_DBW-1:0] mask;
        logic [TL_DW-1:0]  data;
        logic [TL_AUW-1:0] user;
    } req_payload_t;

    typedef struct packed {
        tl_d_op_e          opcode;
        logic [2:0]        param;
        logic [TL_SZW-1:0] size;
        logic [TL_AIW-1:0] source;
        logic [TL_DIW-1:0] sink;
        logic [TL_DW-1:0]  data;
        logic [TL_DUW-1:0] user;
        logic              error;
    } rsp_payload_t;

    req_payload_t        req_wdata;
    req_payload_t        req_rdata;
    rsp_payload_t        rsp_wdata;
    rsp_payload_t        rsp_rdata;
    logic                req_wvalid;
    logic                req_wready;
    logic                req_rvalid;
    logic [ReqCntW-1:0]  req_depth;
    logic                rsp_wready;
    logic                rsp_rvalid;
    logic [RspCntW-1:0]  rsp_depth;
    logic                below_limit;
    logic                h_a_ready;
    logic                h_a_acc;
    logic                h_d_acc;
    logic [OutW-1:0]     outstanding_q;
    logic [OutW-1:0]     outstanding_d;

    // Host a_ready depends only on registered state, never on a_valid.
    assign below_limit = (outstanding_q < OutW'(MaxOutstanding));
    assign h_a_ready   = req_wready && below_limit;
    assign req_wvalid  = tl_h_i.a_valid && below_limit;
    assign h_a_acc     = tl_h_i.a_valid && h_a_ready;
    assign h_d_acc     = rsp_rvalid && tl_h_i.d_ready;

    always_comb begin
        req_wdata = '{
            opcode:  tl_h_i.a_opcode,
            param:   tl_h_i.a_param,
            size:    tl_h_i.a_size,
            source:  tl_h_i.a_source,
            address: tl_h_i.a_address,
            mask:    tl_h_i.a_mask,
            data:    tl_h_i.a_data,
            user:    tl_h_i.a_user
        };
        rsp_wdata = '{
            opcode: tl_d_i.d_opcode,
            param:  tl_d_i.d_param,
            size:   tl_d_i.d_size,
            source: tl_d_i.d_source,
            sink:   tl_d_i.d_sink,
            data:   tl_d_i.d_data,
            user:   tl_d_i.d_user,
            error:  tl_d_i.d_error
        };
    end

    tlul_bridge_fifo #(
        .Width ($bits(req_payload_t)),
        .Depth (ReqDepth)
    ) u_req_fifo (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .wvalid (req_wvalid),
        .wready (req_wready),
        .wdata  (req_wdata),
        .rvalid (req_rvalid),
        .rready (tl_d_i.a_ready),
        .rdata  (req_rdata),
        .depth  (req_depth)
    );

    tlul_bridge_fifo #(
        .Width ($bits(rsp_payload_t)),
        .Depth (RspDepth)
    ) u_rsp_fifo (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .wvalid (tl_d_i.d_valid),
        .wready (rsp_wready),
        .wdata  (rsp_wdata),
        .rvalid (rsp_rvalid),
        .rready (tl_h_i.d_ready),
        .rdata  (rsp_rdata),
        .depth  (rsp_depth)
    );

    always_comb begin
        tl_d_o = '{
            a_valid:   req_rvalid,
            a_opcode:  req_rdata.opcode,
            a_param:   req_rdata.param,
            a_size:    req_rdata.size,
            a_source:  req_rdata.source,
            a_address: req_rdata.address,
            a_mask:    req_rdata.mask,
            a_data:    req_rdata.data,
            a_user:    req_rdata.user,
            d_ready:   rsp_wready
        };
        tl_h_o = '{
            d_valid:  rsp_rvalid,
            d_opcode: rsp_rdata.opcode,
            d_param:  rsp_rdata.param,
            d_size:   rsp_rdata.size,
            d_source: rsp_rdata.source,
            d_sink:   rsp_rdata.sink,
            d_data:   rsp_rdata.data,
            d_user:   rsp_rdata.user,
            d_error:  rsp_rdata.error,
            a_ready:  h_a_ready
        };
    end

    always_comb begin
        outstanding_d = outstanding_q;
        if (h_a_acc && !h_d_acc) begin
            outstanding_d = outstanding_q + OutW'(1);
        end else if (h_d_acc && !h_a_acc) begin
            outstanding_d = outstanding_q - OutW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            outstanding_q <= '0;
        end else begin
            outstanding_q <= outstanding_d;
        end
    end

    assign outstanding_o = outstanding_q;
    assign idle_o = (req_depth == '0) && (rsp_depth == '0) && (outstanding_q == '0);

    if (ReqDepth < 1) begin : gen_req_depth_check
        $error("tlul_peri_bridge: ReqDepth must be >= 1");
    end
    if (MaxOutstanding < 1) begin : gen_max_out_check
        $error("tlul_peri_bridge: MaxOutstanding must be >= 1");
    end
    if (RspDepth < MaxOutstanding) begin : gen_rsp_depth_check
        $error("tlul_peri_bridge: RspDepth must be >= MaxOutstanding");
    end

    a_out_limit: assert property (@(posedge clk_i) disable iff (!rst_ni)
        outstanding_q <= OutW'(MaxOutstanding));
    a_no_d_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        h_d_acc |-> (outstanding_q != '0));

endmodule

// File: tb/tb_tlul_peri_bridge.sv
// Bench for tlul_peri_bridge: queue-based bridge model checked every cycle, a host driver,
// an auto-responding device, and directed scenarios with literal expectations.
module tb_tlul_peri_bridge;
    import tlul_pkg::*;

    localparam int ReqDepth = 2;
    localparam int RspDepth = 2;
    localparam int MaxOut   = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    tl_h2d_t     tl_h_i = '0;
    tl_d2h_t     tl_h_o;
    tl_h2d_t     tl_d_o;
    tl_d2h_t     tl_d_i = '0;
    logic [1:0]  outstanding_o;
    logic        idle_o;

    int checks = 0;
    int errors = 0;

    // Stimulus controls
    logic    h_d_ready = 1'b1;
    logic    dev_a_ready = 1'b1;
    int      rsp_delay = 1;
    tl_h2d_t hq[$];

    // Model state
    tl_h2d_t reqq[$];
    tl_d2h_t rspq[$];
    tl_d2h_t pend[$];
    int      pdue[$];
    tl_d2h_t got[$];
    int      outs = 0;
    int      cyc = 0;
    logic    saw_block = 1'b0;

    always #5 clk = ~clk;

    tlul_peri_bridge #(
        .ReqDepth       (ReqDepth),
        .RspDepth       (RspDepth),
        .MaxOutstanding (MaxOut)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .tl_h_i        (tl_h_i),
        .tl_h_o        (tl_h_o),
        .tl_d_o        (tl_d_o),
        .tl_d_i        (tl_d_i),
        .outstanding_o (outstanding_o),
        .idle_o        (idle_o)
    );

    function automatic void chk(input string nm, input logic [127:0] act,
                                input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    function automatic tl_h2d_t mk_req(input logic [31:0] addr, input logic [7:0] src);
        tl_h2d_t q;
        q = '0;
        q.a_opcode  = Get;
        q.a_size    = 2'd2;
        q.a_source  = src;
        q.a_address = addr;
        q.a_mask    = 4'hF;
        q.a_data    = {addr[15:0], 16'hBEEF};
        q.a_user    = {8'hA0, src};
        return q;
    endfunction

    function automatic tl_d2h_t make_rsp(input tl_h2d_t q);
        tl_d2h_t r;
        r = '0;
        r.d_opcode = AccessAckData;
        r.d_size   = q.a_size;
        r.d_source = q.a_source;
        r.d_sink   = 1'b1;
        r.d_data   = q.a_address ^ 32'h1234_5678;
        r.d_user   = q.a_user;
        r.d_error  = (q.a_address[7:0] == 8'hEE);
        return r;
    endfunction

    // Bridge model: bounded in-order queues plus an outstanding count.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reqq.delete();
            rspq.delete();
            pend.delete();
            pdue.delete();
            outs = 0;
        end else begin
            logic    h_acc, dev_acc, rsp_push, h_dacc;
            tl_d2h_t r;
            tl_h2d_t q;
            cyc++;
            h_acc    = tl_h_i.a_valid && (reqq.size() < ReqDepth) && (outs < MaxOut);
            dev_acc  = (reqq.size() > 0) && tl_d_i.a_ready;
            rsp_push = tl_d_i.d_valid && (rspq.size() < RspDepth);
            h_dacc   = (rspq.size() > 0) && tl_h_i.d_ready;
            if (tl_h_o.d_valid && tl_h_i.d_ready) got.push_back(tl_h_o);
            r = tl_d_i;
            r.d_valid = 1'b0;
            r.a_ready = 1'b0;
            if (rsp_push && pend.size() > 0) begin
                void'(pend.pop_front());
                void'(pdue.pop_front());
            end
            if (dev_acc) begin
                pend.push_back(make_rsp(reqq[0]));
                pdue.push_back(cyc + rsp_delay - 1);
                void'(reqq.pop_front());
            end
            if (h_acc) begin
                q = tl_h_i;
                q.a_valid = 1'b0;
                q.d_ready = 1'b0;
                reqq.push_back(q);
            end
            if (h_dacc) void'(rspq.pop_front());
            if (rsp_push) rspq.push_back(r);
            outs = outs + int'(h_acc) - int'(h_dacc);
        end
    end

    // Host and device drivers.
    always @(posedge clk) begin
        if (rst_n && tl_h_i.a_valid && tl_h_o.a_ready && hq.size() > 0) void'(hq.pop_front());
        #1;
        tl_h_i = '0;
        if (hq.size() > 0) begin
            tl_h_i = hq[0];
            tl_h_i.a_valid = 1'b1;
        end
        tl_h_i.d_ready = h_d_ready;
        tl_d_i = '0;
        if (pend.size() > 0 && cyc >= pdue[0]) begin
            tl_d_i = pend[0];
            tl_d_i.d_valid = 1'b1;
        end
        tl_d_i.a_ready = dev_a_ready;
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        tl_h2d_t ar;
        tl_d2h_t dr;
        chk("h_a_ready", 128'(tl_h_o.a_ready), 128'((reqq.size() < ReqDepth) && (outs < MaxOut)));
        chk("d_a_valid", 128'(tl_d_o.a_valid), 128'(reqq.size() > 0));
        chk("d_d_ready", 128'(tl_d_o.d_ready), 128'(rspq.size() < RspDepth));
        chk("h_d_valid", 128'(tl_h_o.d_valid), 128'(rspq.size() > 0));
        chk("outstanding", 128'(outstanding_o), 128'(outs));
        chk("idle", 128'(idle_o), 128'(reqq.size() == 0 && rspq.size() == 0 && outs == 0));
        if (reqq.size() > 0) begin
            ar = tl_d_o;
            ar.a_valid = 1'b0;
            ar.d_ready = 1'b0;
            chk("d_a_payload", 128'(ar), 128'(reqq[0]));
        end
        if (rspq.size() > 0) begin
            dr = tl_h_o;
            dr.d_valid = 1'b0;
            dr.a_ready = 1'b0;
            chk("h_d_payload", 128'(dr), 128'(rspq[0]));
        end
        if (!tl_h_o.a_ready && outstanding_o == 2'd2) saw_block = 1'b1;
    end

    task automatic wait_quiet(input int maxc, input string nm);
        logic done;
        done = 1'b0;
        for (int i = 0; i < maxc && !done; i++) begin
            @(negedge clk);
            if (hq.size() == 0 && pend.size() == 0 && reqq.size() == 0 &&
                rspq.size() == 0 && outs == 0) done = 1'b1;
        end
        chk(nm, 128'(done), 128'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic done;
        // Reset state
        #1;
        chk("rst_a_valid", 128'(tl_d_o.a_valid), 128'(0));
        chk("rst_d_valid", 128'(tl_h_o.d_valid), 128'(0));
        chk("rst_a_ready", 128'(tl_h_o.a_ready), 128'(1));
        chk("rst_d_ready", 128'(tl_d_o.d_ready), 128'(1));
        chk("rst_outstanding", 128'(outstanding_o), 128'(0));
        chk("rst_idle", 128'(idle_o), 128'(1));
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single Get, device responds 2 cycles after accept
        rsp_delay = 2;
        got.delete();
        hq.push_back(mk_req(32'h4000_0010, 8'd3));
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (hq.size() == 0) done = 1'b1;
        end
        chk("single_accept", 128'(done), 128'(1));
        chk("single_a_valid", 128'(tl_d_o.a_valid), 128'(1));
        chk("single_addr", 128'(tl_d_o.a_address), 128'(32'h4000_0010));
        chk("single_src", 128'(tl_d_o.a_source), 128'(3));
        chk("single_out1", 128'(outstanding_o), 128'(1));
        wait_quiet(40, "single_quiet");
        chk("single_ngot", 128'(got.size()), 128'(1));
        if (got.size() > 0) begin
            chk("single_rsp_src", 128'(got[0].d_source), 128'(3));
            chk("single_rsp_data", 128'(got[0].d_data), 128'(32'h5234_5668));
        end
        chk("single_out0", 128'(outstanding_o), 128'(0));

        // Back-to-back Gets, limit reached then drained in order
        rsp_delay = 1;
        saw_block = 1'b0;
        got.delete();
        for (int i = 0; i < 4; i++) hq.push_back(mk_req(32'h4000_0100 + 32'(4 * i), 8'(i)));
        wait_quiet(80, "b2b_quiet");
        chk("b2b_blocked", 128'(saw_block), 128'(1));
        chk("b2b_ngot", 128'(got.size()), 128'(4));
        for (int i = 0; i < 4 && i < got.size(); i++) begin
            chk("b2b_order", 128'(got[i].d_source), 128'(i));
            chk("b2b_data", 128'(got[i].d_data), 128'((32'h4000_0100 + 32'(4 * i)) ^ 32'h1234_5678));
        end

        // Device stalls a_ready while host issues 3 requests
        dev_a_ready = 1'b0;
        got.delete();
        @(negedge clk);
        for (int i = 0; i < 3; i++) hq.push_back(mk_req(32'h4000_0200 + 32'(4 * i), 8'(16 + i)));
        repeat (6) @(negedge clk);
        chk("stall_out2", 128'(outstanding_o), 128'(2));
        chk("stall_a_ready", 128'(tl_h_o.a_ready), 128'(0));
        chk("stall_pending", 128'(hq.size()), 128'(1));
        dev_a_ready = 1'b1;
        wait_quiet(80, "stall_quiet");
        chk("stall_ngot", 128'(got.size()), 128'(3));
        for (int i = 0; i < 3 && i < got.size(); i++)
            chk("stall_order", 128'(got[i].d_source), 128'(16 + i));

        // Host stalls d_ready, second response carries d_error
        h_d_ready = 1'b0;
        got.delete();
        @(negedge clk);
        hq.push_back(mk_req(32'h4000_0300, 8'd5));
        hq.push_back(mk_req(32'h4000_03EE, 8'd6));
        done = 1'b0;
        for (int i = 0; i < 30 && !done; i++) begin
            @(negedge clk);
            if (rspq.size() == 2) done = 1'b1;
        end
        chk("derr_buffered", 128'(done), 128'(1));
        chk("derr_d_valid", 128'(tl_h_o.d_valid), 128'(1));
        chk("derr_head_err", 128'(tl_h_o.d_error), 128'(0));
        chk("derr_out2", 128'(outstanding_o), 128'(2));
        h_d_ready = 1'b1;
        wait_quiet(40, "derr_quiet");
        chk("derr_ngot", 128'(got.size()), 128'(2));
        if (got.size() == 2) begin
            chk("derr_first", 128'({got[0].d_source, got[0].d_error}), 128'({8'd5, 1'b0}));
            chk("derr_second", 128'({got[1].d_source, got[1].d_error}), 128'({8'd6, 1'b1}));
        end

        // Reset mid-transaction with one request and one response buffered
        h_d_ready = 1'b0;
        @(negedge clk);
        hq.push_back(mk_req(32'h4000_0400, 8'd9));
        done = 1'b0;
        for (int i = 0; i < 30 && !done; i++) begin
            @(negedge clk);
            if (rspq.size() == 1) done = 1'b1;
        end
        chk("mid_rsp_buf", 128'(done), 128'(1));
        dev_a_ready = 1'b0;
        @(negedge clk);
        hq.push_back(mk_req(32'h4000_0404, 8'd10));
        done = 1'b0;
        for (int i = 0; i < 30 && !done; i++) begin
            @(negedge clk);
            if (reqq.size() == 1 && hq.size() == 0) done = 1'b1;
        end
        chk("mid_req_buf", 128'(done), 128'(1));
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_a_valid", 128'(tl_d_o.a_valid), 128'(0));
        chk("arst_d_valid", 128'(tl_h_o.d_valid), 128'(0));
        chk("arst_a_ready", 128'(tl_h_o.a_ready), 128'(1));
        chk("arst_d_ready", 128'(tl_d_o.d_ready), 128'(1));
        chk("arst_outstanding", 128'(outstanding_o), 128'(0));
        chk("arst_idle", 128'(idle_o), 128'(1));
        hq.delete();
        dev_a_ready = 1'b1;
        h_d_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_a_valid", 128'(tl_d_o.a_valid), 128'(0));
        chk("post_d_valid", 128'(tl_h_o.d_valid), 128'(0));
        chk("post_idle", 128'(idle_o), 128'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
